fetch_unit: RTL

- Instruction-fetch front end that sits directly upstream of the decode stage and replaces the bare PC register plus combinational instruction-memory lookup.
- Owns the fetch PC and issues in-order requests to an instruction memory with variable latency (req/gnt, then rvalid).
- Buffers returned words in a small prefetch FIFO and presents one {pc, inst} pair per cycle to decode.
- Honours the decode-stage hazard stall and the execute-stage jump redirect.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO of fetch entries; clear wins over push/pop,
// and push into a full FIFO is accepted only alongside a real pop.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         clear,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (32'(count) == DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; head is only consumed when the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, issues in-order imem requests, buffers
// responses in a prefetch FIFO and hands one {pc, inst} per cycle to decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jump_flag,
  input  logic [31:0] jump_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t  state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [31:0]   pc_after_pop;
  logic [OW-1:0] outstanding, outstanding_next;
  logic [OW-1:0] kill_cnt, kill_cnt_next;
  logic          grant;
  logic          keep_resp;
  logic          pop;

  fetch_entry_t   buf_head, buf_in;
  fetch_entry_t   tag_head, tag_in;
  logic [FCW-1:0] buf_count;
  logic           buf_full, buf_empty;
  logic [OW-1:0]  tag_count;
  logic           tag_full, tag_empty;
  logic           unused;

  // Issue only when every in-flight response is guaranteed a buffer slot.
  assign imem_req  = (state == RUN)
                  && (32'(outstanding) < MAX_OUTSTANDING)
                  && ((32'(buf_count) + 32'(outstanding)) < FIFO_DEPTH);
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;
  assign keep_resp = imem_rvalid && (outstanding != '0) && (kill_cnt == '0) && !jump_flag;

  assign if_valid = !buf_empty;
  assign pop      = if_valid && !stall && !jump_flag;
  assign if_pc    = buf_empty ? pc_after_pop : buf_head.pc;
  assign if_inst  = buf_empty ? NOP_INST : buf_head.inst;

  assign buf_in = '{pc: tag_head.pc, inst: imem_rdata};
  assign tag_in = '{pc: fetch_pc, inst: 32'h0};

  assign unused = ^{buf_full, tag_head.inst, tag_count, tag_full, tag_empty, jump_target[1:0]};

  // Next-state: a jump overrides everything and turns all in-flight requests into kills.
  always_comb begin
    state_next       = state;
    fetch_pc_next    = fetch_pc;
    outstanding_next = outstanding;
    kill_cnt_next    = kill_cnt;

    if (grant) outstanding_next = outstanding_next + OW'(1);
    if (imem_rvalid && (outstanding != '0)) outstanding_next = outstanding_next - OW'(1);

    if (jump_flag) begin
      fetch_pc_next = {jump_target[31:2], 2'b00};
      kill_cnt_next = outstanding_next;
      state_next    = (outstanding_next != '0) ? FLUSH : RUN;
    end else begin
      if (grant) fetch_pc_next = fetch_pc + 32'd4;
      if (imem_rvalid && (kill_cnt != '0)) kill_cnt_next = kill_cnt - OW'(1);
      case (state)
        BOOT:    state_next = RUN;
        FLUSH:   if (kill_cnt == '0) state_next = RUN;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= BOOT;
      fetch_pc     <= RESET_PC;
      outstanding  <= '0;
      kill_cnt     <= '0;
      pc_after_pop <= RESET_PC;
    end else begin
      state       <= state_next;
      fetch_pc    <= fetch_pc_next;
      outstanding <= outstanding_next;
      kill_cnt    <= kill_cnt_next;
      if (pop) pc_after_pop <= buf_head.pc + 32'd4;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_prefetch (
    .clk       (clk),
    .reset     (reset),
    .push      (keep_resp),
    .push_data (buf_in),
    .pop       (pop),
    .clear     (jump_flag),
    .head      (buf_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // Tags of granted addresses, consumed in order as kept responses arrive.
  fetch_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tags (
    .clk       (clk),
    .reset     (reset),
    .push      (grant && !jump_flag),
    .push_data (tag_in),
    .pop       (keep_resp),
    .clear     (jump_flag),
    .head      (tag_head),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

`ifndef SYNTHESIS
  rvalid_needs_request: assert property (@(posedge clk) disable iff (reset)
    imem_rvalid |-> (outstanding != '0));
`endif

endmodule
